// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the opcodes, the AluOp / ALUSrcB / PCSource encodings, the FSM state
// encoding and the packed bundle of datapath control signals.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode for the multicycle MIPS control FSM.
// Ports:
//   state - current FSM state (raw 4-bit value; 12-15 decode to all zero)
//   ready - effective memory ready; gates IRWrite/PCWrite in FETCH
//   ctrl  - bundle of datapath enables and mux selects
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       ready,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // PC+4 and the IR are only committed once the fetch actually lands.
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_ADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j,
// addi). Holds the state register and next-state logic; outputs come from
// mips_ctrl_decode.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   opcode              - instr[31:26] from the instruction register
//   mem_ready           - memory finished the current access this cycle
//   PCWrite..PCSource   - datapath enables and mux selects
//   illegal_op          - one-cycle pulse in DECODE on an unsupported opcode
//   state_o             - current state, for debug
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         AluOp,
  output logic [1:0]         PCSource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ready;
  ctrl_t      ctrl;

  assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    illegal_op = 1'b0;
    case (state_q)
      FETCH:     state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      // The IR still holds lw or sw here, so the opcode is stable.
      MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = ready ? FETCH : MEM_WRITE;
      EXECUTE:   state_d = R_WB;
      ADDI_EX:   state_d = ADDI_WB;
      // MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB and unused codes all go to FETCH.
      default:   state_d = FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state (state_q),
    .ready (ready),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign AluOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed scenarios plus
// randomized instruction streams with random memory wait states, compared
// per cycle against a path-based model of the instruction sequencing.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, AluOp, PCSource;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.USE_MEM_READY(1), .STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .AluOp       (AluOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] outs_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, illegal_op};
  endfunction

  // Expected control word for a state, written from the per-state output list.
  function automatic logic [17:0] exp_out(input int st, input bit rdy, input bit ill);
    bit pcw = 0, pcc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0;
    bit rdst = 0, rw = 0, sa = 0;
    bit [1:0] sb = 0, aop = 0, pcs = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, pcs, ill};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Runs one instruction from FETCH until its last state. In directed mode the
  // first fetch_wait FETCH cycles and first mem_wait memory cycles see
  // mem_ready=0; in random mode mem_ready is random every cycle.
  task automatic run_instr(input logic [5:0] op, input bit rand_ready,
                           input int fetch_wait, input int mem_wait);
    int  path[$];
    int  idx  = 0;
    int  fw   = fetch_wait;
    int  mw   = mem_wait;
    bit  done = 0;
    bit  rdy;
    int  st;
    case (op)
      6'b000000: path = '{0, 1, 6, 7};
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
      6'b001000: path = '{0, 1, 10, 11};
      default:   path = '{0, 1};
    endcase
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      st = path[idx];
      if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
      else if (st == 0) begin rdy = (fw == 0); if (fw > 0) fw--; end
      else if (st == 3 || st == 5) begin rdy = (mw == 0); if (mw > 0) mw--; end
      else rdy = 1'b1;
      opcode    = op;
      mem_ready = rdy;
      #1;
      check($sformatf("state op=%b c=%0d", op, c), 32'(state_o), 32'(st));
      check($sformatf("outs op=%b st=%0d rdy=%0d", op, st, rdy), 32'(outs_now()),
            32'(exp_out(st, rdy, (st == 1) && !is_legal(op))));
      check("inv_mem_rw", 32'(MemRead & MemWrite), 32'd0);
      check("inv_pcw", 32'(PCWrite & PCWriteCond), 32'd0);
      if ((st == 0 || st == 3 || st == 5) && !rdy) ;
      else idx++;
      if (idx == path.size()) begin done = 1; break; end
    end
    if (!done) check("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b001000};
    logic [5:0] op;

    reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
    #2;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outs", 32'(outs_now()), 32'(exp_out(0, 1'b1, 1'b0)));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a stalled sw: MemWrite must drop immediately.
    opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    check("sw_stall_state", 32'(state_o), 32'd5);
    check("sw_stall_memwrite", 32'(MemWrite), 32'd1);
    #1 reset = 1'b1; #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_memwrite", 32'(MemWrite), 32'd0);
    check("arst_memread", 32'(MemRead), 32'd1);
    check("arst_illegal", 32'(illegal_op), 32'd0);
    check("arst_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Directed scenarios.
    run_instr(6'b000000, 0, 0, 0);   // R-type
    run_instr(6'b100011, 0, 0, 2);   // lw, 2 wait cycles in MEM_READ
    run_instr(6'b101011, 0, 0, 0);   // sw
    run_instr(6'b000100, 0, 0, 0);   // beq
    run_instr(6'b000010, 0, 0, 0);   // j
    run_instr(6'b001000, 0, 0, 0);   // addi
    run_instr(6'b111111, 0, 0, 0);   // illegal
    run_instr(6'b000000, 0, 4, 0);   // 4-cycle fetch stall
    run_instr(6'b101011, 0, 0, 3);   // sw with write stall

    // Randomized instruction stream with random memory waits.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        for (int t = 0; t < 16 && is_legal(op); t++) op = 6'($urandom);
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
